// File: rtl/local_bus_pkg.sv
// Shared types and constants for the k30p local bus controller.
package local_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        BERR,
        EXTERN
    } state_t;

    typedef enum logic [1:0] {
        TARGET_RAM,
        TARGET_ROM,
        TARGET_SERIAL
    } target_t;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    // Port-size encoding the CPU expects for each local target.
    function automatic logic [1:0] dsack_code(input target_t target);
        logic [1:0] code;
        case (target)
            TARGET_RAM:    code = DSACK_32;
            TARGET_ROM:    code = DSACK_16;
            TARGET_SERIAL: code = DSACK_8;
            default:       code = DSACK_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/local_bus_controller_watchdog.sv
// bus_watchdog: 8-bit cycle counter that flags an external bus cycle which
// has run for TIMEOUT cycles without any response from the VME bridge.
module bus_watchdog
    import local_bus_pkg::*;
#(
    parameter int TIMEOUT = 200
) (
    input  logic clock,
    input  logic n_reset,
    input  logic count_en,
    input  logic clear,
    input  logic freeze,
    output logic expired
);

    logic [7:0] count;

    // Count while enabled and not frozen, saturating at the limit so the
    // expiry indication cannot wrap away.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !freeze && (count != 8'(TIMEOUT))) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT));

endmodule

// File: rtl/local_bus_controller.sv
// local_bus_controller: sequences 68030 bus cycles for the local RAM, ROM
// and serial peripherals, returning DSACK with per-target wait states and
// port size, and BERR for unmapped addresses. Defining LOCAL_BUS_TIMEOUT_EN
// adds a watchdog that bus-errors external cycles that never terminate.
module local_bus_controller
    import local_bus_pkg::*;
#(
    parameter int RAM_WAIT    = 1,
    parameter int ROM_WAIT    = 3,
    parameter int SERIAL_WAIT = 4,
    parameter int TIMEOUT     = 200
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       cpu_as,
    input  logic       cpu_ds,
    input  logic       request_ram,
    input  logic       request_rom,
    input  logic       request_serial,
    input  logic       request_unmapped,
    input  logic [1:0] ext_dsack,
    input  logic       ext_berr,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr,
    output logic       timeout_flag,
    input  logic       timeout_clear
);

    state_t     state, state_next;
    target_t    target, target_next;
    logic [3:0] wait_count, wait_count_next;
    logic [1:0] dsack_next;
    logic       berr_next;
    logic       wd_clear;
    logic       wd_expired;
    logic       timeout_hit;
    logic       ext_active;

    assign ext_active = (ext_dsack != DSACK_NONE) || (ext_berr == ACTIVE);

    // Bus cycle state, latched target, wait counter and the registered
    // CPU-facing strobes.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            target     <= TARGET_RAM;
            wait_count <= '0;
            cpu_dsack  <= DSACK_NONE;
            cpu_berr   <= INACTIVE;
        end else begin
            state      <= state_next;
            target     <= target_next;
            wait_count <= wait_count_next;
            cpu_dsack  <= dsack_next;
            cpu_berr   <= berr_next;
        end
    end

    // Next-state and next-output decisions; DSACK only leaves NONE on the
    // way into ACK and BERR only asserts while in BERR, so they never overlap.
    always_comb begin
        state_next      = state;
        target_next     = target;
        wait_count_next = wait_count;
        dsack_next      = cpu_dsack;
        berr_next       = cpu_berr;
        wd_clear        = 1'b0;
        timeout_hit     = 1'b0;

        case (state)
            IDLE: begin
                dsack_next = DSACK_NONE;
                berr_next  = INACTIVE;
                if (cpu_as == ACTIVE) begin
                    if (request_ram == ACTIVE) begin
                        target_next     = TARGET_RAM;
                        wait_count_next = 4'(RAM_WAIT);
                        state_next      = WAIT;
                    end else if (request_rom == ACTIVE) begin
                        target_next     = TARGET_ROM;
                        wait_count_next = 4'(ROM_WAIT);
                        state_next      = WAIT;
                    end else if (request_serial == ACTIVE) begin
                        target_next     = TARGET_SERIAL;
                        wait_count_next = 4'(SERIAL_WAIT);
                        state_next      = WAIT;
                    end else if (request_unmapped == ACTIVE) begin
                        state_next = BERR;
                    end else begin
                        wd_clear   = 1'b1;
                        state_next = EXTERN;
                    end
                end
            end
            WAIT: begin
                if (cpu_as == INACTIVE) begin
                    state_next = IDLE;
                end else if (wait_count != 4'd0) begin
                    wait_count_next = wait_count - 4'd1;
                end else if (cpu_ds == ACTIVE) begin
                    dsack_next = dsack_code(target);
                    state_next = ACK;
                end
            end
            ACK: begin
                if (cpu_as == INACTIVE) begin
                    dsack_next = DSACK_NONE;
                    state_next = IDLE;
                end
            end
            BERR: begin
                if (cpu_as == INACTIVE) begin
                    berr_next  = INACTIVE;
                    state_next = IDLE;
                end else begin
                    berr_next = ACTIVE;
                end
            end
            EXTERN: begin
                if (cpu_as == INACTIVE) begin
                    state_next = IDLE;
                end else if (wd_expired && !ext_active) begin
                    timeout_hit = 1'b1;
                    state_next  = BERR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef LOCAL_BUS_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .n_reset  (n_reset),
        .count_en (state == EXTERN),
        .clear    (wd_clear),
        .freeze   (ext_active),
        .expired  (wd_expired)
    );

    // Sticky timeout indication; a new timeout beats a simultaneous clear.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end else if (timeout_clear) begin
            timeout_flag <= 1'b0;
        end
    end
`else
    logic unused_watchdog;

    assign wd_expired      = 1'b0;
    assign timeout_flag    = 1'b0;
    assign unused_watchdog = &{1'b0, wd_clear, timeout_hit, timeout_clear, 8'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_local_bus_controller.sv
// Scoreboard bench for local_bus_controller: stimulus queues the expected
// output changes with the edge they must follow; a negedge monitor pops and
// compares whenever the DUT outputs change. Honours LOCAL_BUS_TIMEOUT_EN.
module tb_local_bus_controller;

    typedef struct {
        string      name;
        logic [1:0] dsack;
        logic       berr;
        logic       flag;
        int         at_edge;
    } event_t;

    logic       clock;
    logic       n_reset;
    logic       cpu_as;
    logic       cpu_ds;
    logic       request_ram;
    logic       request_rom;
    logic       request_serial;
    logic       request_unmapped;
    logic [1:0] ext_dsack;
    logic       ext_berr;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;
    logic       timeout_flag;
    logic       timeout_clear;

    event_t     exp_q[$];
    int         edge_no = 0;
    int         checks_total = 0;
    int         checks_passed = 0;
    logic       monitor_on = 1'b0;
    logic [3:0] last_seen = 4'b1110;
    logic       exp_berr_timeout;
    logic       exp_flag_timeout;

    local_bus_controller #(
        .RAM_WAIT    (1),
        .ROM_WAIT    (3),
        .SERIAL_WAIT (4),
        .TIMEOUT     (10)
    ) dut (
        .clock            (clock),
        .n_reset          (n_reset),
        .cpu_as           (cpu_as),
        .cpu_ds           (cpu_ds),
        .request_ram      (request_ram),
        .request_rom      (request_rom),
        .request_serial   (request_serial),
        .request_unmapped (request_unmapped),
        .ext_dsack        (ext_dsack),
        .ext_berr         (ext_berr),
        .cpu_dsack        (cpu_dsack),
        .cpu_berr         (cpu_berr),
        .timeout_flag     (timeout_flag),
        .timeout_clear    (timeout_clear)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Number of rising edges seen so far.
    always @(posedge clock) edge_no <= edge_no + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic as_v, input logic ds_v, input logic ram_v,
                                 input logic rom_v, input logic ser_v, input logic unm_v);
        cpu_as           = as_v;
        cpu_ds           = ds_v;
        request_ram      = ram_v;
        request_rom      = rom_v;
        request_serial   = ser_v;
        request_unmapped = unm_v;
    endtask

    task automatic expectEvent(input string name, input logic [1:0] d, input logic b,
                               input logic f, input int at);
        event_t e;
        e.name    = name;
        e.dsack   = d;
        e.berr    = b;
        e.flag    = f;
        e.at_edge = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every output change must match the next queued expectation,
    // both in value and in the edge after which it appeared.
    always @(negedge clock) begin
        logic [3:0] current;
        event_t     e;
        if (monitor_on) begin
            current = {cpu_dsack, cpu_berr, timeout_flag};
            if (current !== last_seen) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_change", 32'(current), 32'(last_seen));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.name, "_value"}, 32'(current), 32'({e.dsack, e.berr, e.flag}));
                    checkOutput({e.name, "_edge"}, 32'(edge_no), 32'(e.at_edge));
                end
                last_seen = current;
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL time_limit: got timeout, expected $finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int e0;
        applyStimulus(1, 1, 1, 1, 1, 1);
        ext_dsack     = 2'b11;
        ext_berr      = 1'b1;
        timeout_clear = 1'b0;
        n_reset       = 1'b1;
        #2 n_reset    = 1'b0;
        step(2);
        checkOutput("reset_dsack", 32'(cpu_dsack), 32'(2'b11));
        checkOutput("reset_berr", 32'(cpu_berr), 32'(1'b1));
        checkOutput("reset_flag", 32'(timeout_flag), 32'(1'b0));
        n_reset = 1'b1;
        step(2);
        monitor_on = 1'b1;

        // RAM read, one wait state
        e0 = edge_no + 1;
        applyStimulus(0, 0, 0, 1, 1, 1);
        expectEvent("ram_ack", 2'b00, 1, 0, e0 + 2);
        expectEvent("ram_release", 2'b11, 1, 0, e0 + 5);
        step(5);
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);

        // Serial write with DS arriving three cycles after the wait expires
        e0 = edge_no + 1;
        applyStimulus(0, 1, 1, 1, 0, 1);
        expectEvent("serial_ack", 2'b10, 1, 0, e0 + 8);
        expectEvent("serial_release", 2'b11, 1, 0, e0 + 11);
        step(8);
        cpu_ds = 1'b0;
        step(3);
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);

        // Unmapped access
        e0 = edge_no + 1;
        applyStimulus(0, 0, 1, 1, 1, 0);
        expectEvent("unmapped_berr", 2'b11, 0, 0, e0 + 1);
        expectEvent("unmapped_release", 2'b11, 1, 0, e0 + 4);
        step(4);
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);

        // ROM cycle aborted with two wait states left: nothing may come out
        applyStimulus(0, 0, 1, 0, 1, 1);
        step(2);
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);

        // ROM beats serial; later request changes are ignored
        e0 = edge_no + 1;
        applyStimulus(0, 0, 1, 0, 0, 1);
        expectEvent("rom_ack", 2'b01, 1, 0, e0 + 4);
        expectEvent("rom_release", 2'b11, 1, 0, e0 + 6);
        step(1);
        applyStimulus(0, 0, 0, 1, 1, 1);
        step(5);
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);

        // Reset while in ACK releases DSACK at once
        e0 = edge_no + 1;
        applyStimulus(0, 0, 0, 1, 1, 1);
        expectEvent("pre_reset_ack", 2'b00, 1, 0, e0 + 2);
        expectEvent("reset_release", 2'b11, 1, 0, e0 + 3);
        step(4);
        n_reset = 1'b0;
        applyStimulus(1, 1, 1, 1, 1, 1);
        #1;
        checkOutput("midreset_dsack", 32'(cpu_dsack), 32'(2'b11));
        checkOutput("midreset_berr", 32'(cpu_berr), 32'(1'b1));
        step(1);
        n_reset = 1'b1;
        step(2);

        // Controller is back in IDLE: a fresh RAM cycle acks normally
        e0 = edge_no + 1;
        applyStimulus(0, 0, 0, 1, 1, 1);
        expectEvent("post_reset_ack", 2'b00, 1, 0, e0 + 2);
        expectEvent("post_reset_release", 2'b11, 1, 0, e0 + 4);
        step(4);
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);

        // External cycle with no response; timeout_clear held across the timeout
`ifdef LOCAL_BUS_TIMEOUT_EN
        exp_berr_timeout = 1'b0;
        exp_flag_timeout = 1'b1;
`else
        exp_berr_timeout = 1'b1;
        exp_flag_timeout = 1'b0;
`endif
        e0 = edge_no + 1;
        applyStimulus(0, 0, 1, 1, 1, 1);
        timeout_clear = 1'b1;
`ifdef LOCAL_BUS_TIMEOUT_EN
        expectEvent("timeout_flag_set", 2'b11, 1, 1, e0 + 11);
        expectEvent("timeout_berr", 2'b11, 0, 1, e0 + 12);
        expectEvent("timeout_release", 2'b11, 1, 1, e0 + 14);
        expectEvent("timeout_cleared", 2'b11, 1, 0, e0 + 16);
`endif
        step(12);
        timeout_clear = 1'b0;
        step(2);
        checkOutput("ext_berr_level", 32'(cpu_berr), 32'(exp_berr_timeout));
        applyStimulus(1, 1, 1, 1, 1, 1);
        step(2);
        checkOutput("ext_flag_level", 32'(timeout_flag), 32'(exp_flag_timeout));
        timeout_clear = 1'b1;
        step(1);
        timeout_clear = 1'b0;
        step(2);

        // External cycle answered by the bridge: watchdog frozen, no BERR
        applyStimulus(0, 0, 1, 1, 1, 1);
        step(3);
        ext_dsack = 2'b01;
        step(20);
        checkOutput("freeze_berr", 32'(cpu_berr), 32'(1'b1));
        checkOutput("freeze_flag", 32'(timeout_flag), 32'(1'b0));
        applyStimulus(1, 1, 1, 1, 1, 1);
        ext_dsack = 2'b11;
        step(3);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
